// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: the first requester after last_idx,
// scanning upward with wrap-around, wins.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_idx,
  output logic             any,
  output logic [IDX_W-1:0] win_idx
);

  always_comb begin : pick
    logic [IDX_W-1:0] cand;
    // NOTE: every output gets a default first so no path can infer a latch.
    any     = 1'b0;
    win_idx = last_idx;
    cand    = '0;
    // Scan farthest-first so the nearest requester overwrites and wins.
    for (int k = N_REQ; k >= 1; k--) begin
      cand = last_idx + IDX_W'(k);
      if (req[cand]) begin
        any     = 1'b1;
        win_idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter with grant hold, MAX_HOLD timeout and gap-free handover.
// Optional RR_ARB_ONEHOT_OUT_EN adds a registered one-hot grant output.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout_pulse
`ifdef RR_ARB_ONEHOT_OUT_EN
  ,
  output logic [N_REQ-1:0] gnt_onehot
`endif
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] last_idx, last_idx_nxt;
  logic [IDX_W-1:0] gnt_idx_nxt;
  logic             gnt_valid_nxt;
  logic             timeout_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;

  logic [IDX_W-1:0] pick_last;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             release_drop;
  logic             release_to;

  // In GRANT a handover searches after the current holder, which becomes last_idx.
  assign pick_last    = (state == GRANT) ? gnt_idx : last_idx;
  assign release_drop = !req[gnt_idx];
  assign release_to   = req[gnt_idx] && (hold_cnt == HOLD_LAST);

  rr_pick u_pick (
    .req      (req),
    .last_idx (pick_last),
    .any      (pick_any),
    .win_idx  (pick_idx)
  );

  always_comb begin
    state_nxt     = state;
    last_idx_nxt  = last_idx;
    gnt_idx_nxt   = gnt_idx;
    gnt_valid_nxt = gnt_valid;
    hold_cnt_nxt  = hold_cnt;
    timeout_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          gnt_idx_nxt   = pick_idx;
          gnt_valid_nxt = 1'b1;
          hold_cnt_nxt  = '0;
          state_nxt     = GRANT;
        end
      end
      GRANT: begin
        if (release_drop || release_to) begin
          last_idx_nxt = gnt_idx;
          timeout_nxt  = release_to;
          if (pick_any) begin
            gnt_idx_nxt  = pick_idx;
            hold_cnt_nxt = '0;
          end else begin
            gnt_valid_nxt = 1'b0;
            state_nxt     = IDLE;
          end
        end else begin
          hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last_idx      <= 2'b11;
      gnt_idx       <= 2'b00;
      gnt_valid     <= 1'b0;
      timeout_pulse <= 1'b0;
      hold_cnt      <= '0;
    end else begin
      state         <= state_nxt;
      last_idx      <= last_idx_nxt;
      gnt_idx       <= gnt_idx_nxt;
      gnt_valid     <= gnt_valid_nxt;
      timeout_pulse <= timeout_nxt;
      hold_cnt      <= hold_cnt_nxt;
    end
  end

`ifdef RR_ARB_ONEHOT_OUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_onehot <= '0;
    end else begin
      gnt_onehot <= gnt_valid_nxt ? (N_REQ'(1) << gnt_idx_nxt) : '0;
    end
  end
`endif

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- 4-requester round-robin arbiter with a registered 2-bit grant index.
- Feeds the 2-to-4 decoder directly downstream: gnt_idx drives the decoder select, and the decoder output becomes the one-hot grant bus.
- Adds grant hold while the winner keeps requesting, a programmable max-hold timeout, and gap-free back-to-back re-arbitration.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one grant may persist (legal range 1..256)

Ports:
- clk  input  1  single clock; rising edge
- rst  input  1  asynchronous reset, active-high
- req  input  4  request vector; bit i = agent i requesting, sampled every clk edge
- gnt_idx  output  2  index of granted agent (decoder select)
- gnt_valid  output  1  gnt_idx is a live grant
- timeout_pulse  output  1  one-cycle pulse in the cycle after a grant ends by timeout

Behaviour:
- Reset (async, immediate, also mid-grant):
  - state=IDLE, gnt_idx=2'b00, gnt_valid=0, timeout_pulse=0, hold_cnt=0.
  - last_idx=2'b11, so agent 0 has top priority after reset.
- Pick function: search agents (last_idx+1) mod 4, (last_idx+2) mod 4, ... with wrap-around. The first set req bit wins.
- IDLE:
  - If req==0: stay in IDLE; gnt_valid=0; gnt_idx holds its last value.
  - Else: register winner into gnt_idx, gnt_valid<=1, hold_cnt<=0, go to GRANT.
  - Latency: 1 cycle from req sampled to gnt_valid high.
- GRANT, per cycle:
  - release_drop = !req[gnt_idx].
  - release_to = req[gnt_idx] && (hold_cnt==MAX_HOLD-1).
  - Neither true: hold_cnt<=hold_cnt+1; outputs unchanged.
  - On either release: last_idx<=gnt_idx, then pick using the new last_idx in the same cycle.
    - Winner exists: gnt_idx<=winner, gnt_valid stays 1, hold_cnt<=0, stay in GRANT. No bubble.
    - No winner: gnt_valid<=0, go to IDLE.
- Timeout edge cases:
  - The timed-out agent becomes lowest priority. If it is the sole requester it is re-granted immediately, gnt_idx unchanged, and hold_cnt restarts.
  - timeout_pulse<=1 for exactly one cycle on every release_to. It is never asserted on release_drop.
  - MAX_HOLD=1: every grant lasts exactly one cycle; timeout_pulse fires every cycle a requester remains.
- hold_cnt width is $clog2(MAX_HOLD), minimum 1 bit. It never exceeds MAX_HOLD-1 and never wraps.
- Simultaneous events:
  - New requests arriving during GRANT never preempt the current grant.
  - A req bit that rises and falls between edges is invisible.
- All outputs are registered. No combinational path from req to outputs.

Optional Feature:
- Macro RR_ARB_ONEHOT_OUT_EN.
- Defined: extra output port gnt_onehot [3:0], registered, equal to 1<<gnt_idx when gnt_valid=1, else 4'b0000. It updates in the same cycle as gnt_idx. This allows standalone use without the external decoder.
- Undefined: port absent; the one-hot grant is produced only by the downstream decoder.

Decomposition:
- Package arb_pkg holds:
  - N_REQ=4, IDX_W=2.
  - typedef enum logic {IDLE, GRANT} arb_state_t.
- Sub-module rr_pick: purely combinational; inputs req[3:0] and last_idx[1:0]; outputs any (1) and win_idx[1:0]. The arbiter uses it for both initial and back-to-back picks.

Test Plan:
- Reset, req=4'b0000 for 5 cycles -> gnt_valid=0, gnt_idx=00, timeout_pulse=0 throughout.
- req=4'b0100 from cycle 0, dropped at cycle 3 -> gnt_valid=1 with gnt_idx=10 on cycles 1-3; gnt_valid=0 from cycle 4; timeout_pulse never asserted.
- MAX_HOLD=4, req=4'b1111 held constant -> gnt_idx sequence 0,1,2,3,0 with each grant 4 cycles long. gnt_valid never drops. timeout_pulse fires once per handover.
- Wrap: agent 3 granted then drops while req=4'b1001 -> next cycle gnt_idx=00 with no gap. Agent 0 drops -> gnt_idx=11.
- MAX_HOLD=4, req=4'b0010 held constant -> gnt_idx stays 01 and gnt_valid stays 1; timeout_pulse every 4th cycle.
- rst asserted between edges while gnt_idx=10 and gnt_valid=1 -> gnt_valid=0 immediately. After release with req=4'b0101, the first grant goes to agent 0.
